avst_frame_source: RTL
======================

# avst_frame_source

Parametrised Avalon-ST pixel source that streams whole frames from an on-chip image ROM holding `NUM_IMAGES` pre-loaded pictures. It sits upstream of the VGA output module in place of the single-image streamer. It adds:
- run-time image selection, applied only at frame boundaries;
- configurable stored-pixel and output-channel widths;
- a 2-entry output buffer, so backpressure never drops or repeats a pixel and full throughput is kept.

## Interface
Parameters:
- `WIDTH`, default 640, pixels per line.
- `HEIGHT`, default 480, lines per frame.
- `NUM_IMAGES`, default 3, images stored back-to-back in the ROM. Image `k` starts at address `k*WIDTH*HEIGHT`.
- `PIX_BITS`, default 3, stored bits per pixel. Must be a multiple of 3. `C = PIX_BITS/3` bits per channel, ordered R, G, B from the MSB.
- `OUT_BITS`, default 10, output bits per channel.
- `INIT_FILE`, default "images.mif", ROM initialisation file.

Ports:
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `image_sel` input `max(1,$clog2(NUM_IMAGES))`: requested image. Values ≥ `NUM_IMAGES` are treated as 0.
- `pattern_en` input 1: selects the test pattern (see Configuration).
- `data` output `3*OUT_BITS`: pixel as {R,G,B}.
- `startofpacket` output 1: high with the first pixel of a frame.
- `endofpacket` output 1: high with the last pixel of a frame.
- `valid` output 1: `data`, `startofpacket` and `endofpacket` are valid.
- `ready` input 1: the sink accepts data this cycle.
- `frame_count` output 16: number of completed frames. Wraps modulo 2^16.

## Operation
- **Handshake.** A transfer occurs on any rising edge where `valid && ready`.
- **Address generation.** Column counter `x` runs 0..`WIDTH-1`; line counter `y` runs 0..`HEIGHT-1`. Both are in the read-issue stage.
  - At `x=WIDTH-1`, `x` wraps to 0 and `y` increments.
  - At `y=HEIGHT-1` with `x=WIDTH-1`, both wrap to 0.
  - ROM address = `img*WIDTH*HEIGHT + y*WIDTH + x`. Width is `$clog2(NUM_IMAGES*WIDTH*HEIGHT)`.
- **Image latching.** `img` is loaded from `image_sel` only when a read for `x=0,y=0` is issued. A frame is never mixed between images.
- **ROM.** Synchronous read, latency 1 cycle, read-enable gated. The ROM must infer as block RAM.
- **Output FIFO.** 2 entries, each holding {pixel, sop, eop}.
  - `sop` is tagged when `x=0,y=0`; `eop` when `x=WIDTH-1,y=HEIGHT-1`.
  - A read is issued in a cycle when `occupancy + inflight - pop < 2`, where `pop = valid && ready`.
  - `valid = (occupancy != 0)`. Outputs come from the FIFO head.
- **Colour expansion.** Each C-bit channel is replicated MSB-first and truncated to `OUT_BITS`.
  - C=1: 1 → `0x3FF`, 0 → 0.
  - C=2, OUT_BITS=10: `10b` → `1010101010b`.
- **Frame counter.** `frame_count` increments on each transfer with `endofpacket` high.
- **Reset values.** `valid=0`, `startofpacket=0`, `endofpacket=0`, `data=0`, `frame_count=0`. Counters are zero, `img=0`, the FIFO is empty, and any in-flight read is discarded.
- **Reset mid-frame.** Same as the reset values above. The next frame starts at `x=0,y=0` with `sop`; no `eop` is emitted for the aborted frame.

## Timing
- **First edge after `reset` falls.** The first read is issued.
- **Next edge.** Data enters the FIFO, and `valid` is high from then on. First pixel valid 2 cycles after reset release, with `startofpacket=1`.
- **Throughput.** Sustained 1 pixel/cycle while `ready` stays high.
- **Backpressure.** With `ready` low, the head is held stable. At most 2 reads are outstanding (FIFO plus in-flight), so no pixel is lost.
- **Ready returning.** After `ready` returns high, pixels continue back-to-back with no bubble.
- **Image changes.** A change on `image_sel` takes effect from the next frame's first pixel.
- **Simultaneous events.** Push and pop in the same cycle leave occupancy unchanged.

## Configuration
- **`TEST_PATTERN_EN` defined.** A pattern generator is compiled in.
  - When `pattern_en=1`, latched together with `img` at frame start, the stored pixel is replaced by 8 vertical colour bars.
  - Bar index is `b = (x*8)/WIDTH`. R=`b[2]`, G=`b[1]`, B=`b[0]`, each replicated to `OUT_BITS`.
  - The pattern has the same latency and handshake as ROM data.
- **Not defined.** `pattern_en` is ignored and ROM data is always streamed. No pattern logic is synthesised.

## Test plan
Bench parameters: `WIDTH=4, HEIGHT=2, NUM_IMAGES=2, PIX_BITS=3, OUT_BITS=10`. Image 0 holds pixels 0..7 = `3'b000..3'b111`; image 1 holds `3'b111` everywhere.

1. **Startup and full frame.** Reset 3 cycles, then `ready=1`, `image_sel=0` → `valid` rises 2 cycles after release.
   - First beat: `data=30'h0`, `sop=1`. Eighth beat: `data=30'h3FFFFFFF`, `eop=1`.
   - `frame_count=1` after the eighth beat.
2. **Random backpressure.** Toggle `ready` randomly over 3 frames → the accepted sequence exactly repeats the 8-pixel frame. No duplicates, no drops, and `data` is stable while `valid && !ready`.
3. **Image switch.** Change `image_sel` to 1 mid-frame → the current frame completes with image 0 data, and the next frame is all `30'h3FFFFFFF`.
4. **Reset mid-frame.** Assert reset after beat 5 → `valid=0` on the next edge and `frame_count=0`. Restart gives `sop` with pixel 0.
5. **Throughput.** `ready` held high → 8 consecutive transfers per frame with no gap between frames.
6. **Test pattern.** With `TEST_PATTERN_EN` defined and `pattern_en=1` → line 0 carries bars b=0,2,4,6, i.e. `data` = `30'h0`, `30'h000FFC00`, `30'h3FF00000`, `30'h3FFFFC00`.

Source files
------------

// File: rtl/avst_frame_source.sv
// avst_frame_source: Avalon-ST pixel source streaming whole frames from an on-chip image ROM.
//
// Image k occupies ROM addresses k*WIDTH*HEIGHT .. (k+1)*WIDTH*HEIGHT-1. The image
// (and pattern enable) is sampled only when the read for pixel (0,0) is issued, so a
// frame never mixes two images. A 2-entry output FIFO plus one in-flight ROM read keeps
// full throughput under backpressure without dropping or repeating pixels.
//
// Optional feature macro: TEST_PATTERN_EN compiles in an 8-bar vertical colour-bar
// generator selected by pattern_en. Without it pattern_en is ignored.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   image_sel      requested image (values >= NUM_IMAGES select image 0)
//   pattern_en     select colour bars instead of ROM data (TEST_PATTERN_EN builds only)
//   data           pixel {R,G,B}, each OUT_BITS wide
//   startofpacket  first pixel of a frame
//   endofpacket    last pixel of a frame
//   valid / ready  Avalon-ST handshake
//   frame_count    completed frames, wraps modulo 2^16
module avst_frame_source #(
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned NUM_IMAGES = 3,
  parameter int unsigned PIX_BITS   = 3,
  parameter int unsigned OUT_BITS   = 10,
  parameter string       INIT_FILE  = "images.mif"
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic [((NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1)-1:0] image_sel,
  input  logic                                                    pattern_en,
  output logic [3*OUT_BITS-1:0]                                   data,
  output logic                                                    startofpacket,
  output logic                                                    endofpacket,
  output logic                                                    valid,
  input  logic                                                    ready,
  output logic [15:0]                                             frame_count
);

  localparam int unsigned SelW  = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1;
  localparam int unsigned Depth = NUM_IMAGES * WIDTH * HEIGHT;
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned XW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned C     = PIX_BITS / 3;
  localparam int unsigned DW    = 3 * OUT_BITS;

  // Read-issue stage
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [SelW-1:0]  img_q, img_d, sel_clean, img_rd;
  logic             frame_start, x_last, y_last, rd_en, pop, push;
  logic [AddrW-1:0] rd_addr;

  // ROM stage
  (* ram_init_file = INIT_FILE *) logic [PIX_BITS-1:0] rom_q [Depth];
  logic [PIX_BITS-1:0] rom_data_q;
  logic                inflight_q, rd_sop_q, rd_eop_q;
  logic [DW-1:0]       rom_pix, push_pix;

  // Output FIFO
  logic [DW-1:0] fifo_data_q [2];
  logic          fifo_sop_q  [2];
  logic          fifo_eop_q  [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q;
  logic [15:0]   frame_cnt_q;

  assign frame_start = (x_q == '0) && (y_q == '0);
  assign x_last      = (x_q == XW'(WIDTH - 1));
  assign y_last      = (y_q == YW'(HEIGHT - 1));
  assign sel_clean   = (32'(image_sel) >= NUM_IMAGES) ? '0 : image_sel;
  assign img_rd      = frame_start ? sel_clean : img_q;

  assign valid = (count_q != 2'd0);
  assign pop   = valid && ready;
  assign push  = inflight_q;
  // Keep FIFO occupancy plus outstanding reads at or below two after this cycle's pop.
  assign rd_en = !reset && (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

  assign rd_addr = AddrW'(32'(img_rd) * (WIDTH * HEIGHT) + 32'(y_q) * WIDTH + 32'(x_q));

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    img_d = img_q;
    if (rd_en) begin
      if (frame_start) img_d = sel_clean;
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      img_q      <= '0;
      inflight_q <= 1'b0;
      rd_sop_q   <= 1'b0;
      rd_eop_q   <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      img_q      <= img_d;
      inflight_q <= rd_en;
      if (rd_en) begin
        rd_sop_q <= frame_start;
        rd_eop_q <= x_last && y_last;
      end
    end
  end

  // Read-enable gated synchronous ROM; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rd_en) rom_data_q <= rom_q[rd_addr];
  end

  // Channel expansion: replicate each C-bit channel MSB-first, truncated to OUT_BITS.
  for (genvar i = 0; i < OUT_BITS; i++) begin : g_expand
    assign rom_pix[2*OUT_BITS + OUT_BITS-1-i] = rom_data_q[3*C-1 - (i % C)];
    assign rom_pix[OUT_BITS   + OUT_BITS-1-i] = rom_data_q[2*C-1 - (i % C)];
    assign rom_pix[            OUT_BITS-1-i] = rom_data_q[C-1   - (i % C)];
  end

`ifdef TEST_PATTERN_EN
  logic       pat_q, pat_rd, rd_pat_q;
  logic [2:0] bar_rd, rd_bar_q;

  assign pat_rd = frame_start ? pattern_en : pat_q;
  assign bar_rd = 3'((32'(x_q) * 32'd8) / WIDTH);

  // Pattern travels alongside the ROM read so it sees identical latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q    <= 1'b0;
      rd_pat_q <= 1'b0;
      rd_bar_q <= 3'd0;
    end else if (rd_en) begin
      if (frame_start) pat_q <= pattern_en;
      rd_pat_q <= pat_rd;
      rd_bar_q <= bar_rd;
    end
  end

  assign push_pix = rd_pat_q ? {{OUT_BITS{rd_bar_q[2]}}, {OUT_BITS{rd_bar_q[1]}},
                                {OUT_BITS{rd_bar_q[0]}}} : rom_pix;
`else
  logic unused_pattern_en;
  assign unused_pattern_en = pattern_en;
  assign push_pix          = rom_pix;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_pix;
      fifo_sop_q[wr_ptr_q]  <= rd_sop_q;
      fifo_eop_q[wr_ptr_q]  <= rd_eop_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      frame_cnt_q <= 16'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
      if (pop && fifo_eop_q[rd_ptr_q]) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // Head is forced to zero when empty so stale entries never appear on the bus.
  assign data          = valid ? fifo_data_q[rd_ptr_q] : '0;
  assign startofpacket = valid && fifo_sop_q[rd_ptr_q];
  assign endofpacket   = valid && fifo_eop_q[rd_ptr_q];
  assign frame_count   = frame_cnt_q;

endmodule
